issue_arbiter: RTL and testbench

ISSUE_ARBITER -- requirements
Module: issue_arbiter

---
 rtl/issue_arbiter_pkg.sv | 33 +++
 rtl/issue_predecode.sv | 52 +++++
 rtl/issue_arbiter.sv | 104 ++++++++++
 tb/tb_issue_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/issue_arbiter_pkg.sv
// Shared decode constants, issue-mode encodings and FSM state for the issue arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package issue_arbiter_pkg;

  // Major opcodes referenced by the predecoder
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_COP0    = 6'b010000;

  // Dequeue / issue-valid encodings; 2'b10 is never produced
  localparam logic [1:0] ISSUE_NONE   = 2'b00;
  localparam logic [1:0] ISSUE_SINGLE = 2'b01;
  localparam logic [1:0] ISSUE_DUAL   = 2'b11;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_DS_WAIT = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic       is_branch;
    logic       is_mem;
    logic       is_serial;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
  } slot_info_t;

endpackage

// File: rtl/issue_predecode.sv
// Per-slot class (branch/mem/serial) and destination/source register decode.
// Latency: combinational.
// Backpressure: none; pure decode.
module issue_predecode
  import issue_arbiter_pkg::*;
(
  input  logic [31:0] inst,
  output slot_info_t  info
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_shamt;

  assign opcode       = inst[31:26];
  assign funct        = inst[5:0];
  assign unused_shamt = ^inst[10:6];

  // Classify the instruction and pick its architectural destination
  always_comb begin
    info           = '0;
    info.rs        = inst[25:21];
    info.rt        = inst[20:16];
    info.is_mem    = opcode[5];

    casez (opcode)
      6'b000001, 6'b00001?, 6'b0001??: info.is_branch = 1'b1;
      default:                         info.is_branch = 1'b0;
    endcase

    info.is_serial = (opcode == OP_COP0);

    if (opcode == OP_SPECIAL) begin
      casez (funct)
        6'b00100?:                       info.is_branch = 1'b1;  // JR / JALR
        6'b011???, 6'b0100??, 6'b00110?: info.is_serial = 1'b1;  // mul/div, HI/LO, syscall/break
        default: ;
      endcase
    end

    if (opcode == OP_SPECIAL) begin
      info.dest = inst[15:11];
    end else if (opcode[5:3] == 3'b001 || opcode[5:3] == 3'b100) begin
      info.dest = inst[20:16];
    end else if (opcode == OP_JAL || (opcode == OP_REGIMM && inst[20:17] == 4'b1000)) begin
      info.dest = REG_RA;  // JAL, BLTZAL, BGEZAL link into $31
    end else begin
      info.dest = 5'd0;
    end
  end

endmodule

// File: rtl/issue_arbiter.sv
// Picks 0/1/2 instructions from the queue head per cycle and registers the issue packet.
// Latency: 1 cycle from dequeue (upd_mode_o) to out_*.
// Backpressure: ex_ready_i=0 dequeues nothing and holds the output packet and FSM.
module issue_arbiter
  import issue_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [1:0]  iq_supply_valid_i,
  input  logic [63:0] iq_inst_p_i,
  input  logic [63:0] iq_vaddr_p_i,
  input  logic [1:0]  iq_has_exc_p_i,
  input  logic [9:0]  iq_exccode_p_i,
  input  logic        ex_ready_i,
  output logic [1:0]  upd_mode_o,
  output logic [1:0]  out_valid_o,
  output logic [63:0] out_inst_p_o,
  output logic [63:0] out_vaddr_p_o,
  output logic [1:0]  out_exc_p_o,
  output logic [9:0]  out_exccode_p_o,
  output logic [1:0]  out_is_ds_o
);

  slot_info_t   info0;
  slot_info_t   info1;
  issue_state_e state;
  issue_state_e state_nxt;
  logic [1:0]   mode;
  logic [1:0]   is_ds_nxt;
  logic         hazard;
  logic         dual_ok;
  logic         can_go;

  issue_predecode u_pd0 (.inst(iq_inst_p_i[31:0]),  .info(info0));
  issue_predecode u_pd1 (.inst(iq_inst_p_i[63:32]), .info(info1));

  // Slot1 reading what slot0 writes would need a bypass we do not have
  assign hazard = (info0.dest != 5'd0) &&
                  ((info1.rs == info0.dest) || (info1.rt == info0.dest));

  assign dual_ok = (iq_supply_valid_i == 2'b11) && (iq_has_exc_p_i == 2'b00) &&
                   !info0.is_serial && !info1.is_serial &&
                   !(info0.is_mem && info1.is_mem) && !info1.is_branch &&
                   !hazard && (state == ST_IDLE);

  assign can_go = ex_ready_i && !flush_i && rst;

  // Issue decision: how many to dequeue, delay-slot tags and the next FSM state
  always_comb begin
    mode      = ISSUE_NONE;
    is_ds_nxt = 2'b00;
    state_nxt = state;
    if (can_go) begin
      if (state == ST_DS_WAIT) begin
        if (iq_supply_valid_i != 2'b00) begin
          mode      = ISSUE_SINGLE;
          is_ds_nxt = 2'b01;
          state_nxt = ST_IDLE;
        end
      end else if (info0.is_branch && iq_supply_valid_i == 2'b01) begin
        // Hold the branch until its delay slot is in the queue
        mode = ISSUE_NONE;
      end else if (dual_ok) begin
        mode      = ISSUE_DUAL;
        is_ds_nxt = {info0.is_branch, 1'b0};
      end else if (iq_supply_valid_i != 2'b00) begin
        mode = ISSUE_SINGLE;
        if (info0.is_branch) begin
          state_nxt = ST_DS_WAIT;
        end
      end
    end
  end

  assign upd_mode_o = mode;

  // FSM and registered issue packet; reset and flush both drop any pending delay slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      out_valid_o     <= 2'b00;
      out_is_ds_o     <= 2'b00;
      out_exc_p_o     <= 2'b00;
      out_inst_p_o    <= '0;
      out_vaddr_p_o   <= '0;
      out_exccode_p_o <= '0;
    end else if (flush_i) begin
      state       <= ST_IDLE;
      out_valid_o <= 2'b00;
      out_is_ds_o <= 2'b00;
      out_exc_p_o <= 2'b00;
    end else if (ex_ready_i) begin
      state           <= state_nxt;
      out_valid_o     <= mode;
      out_is_ds_o     <= is_ds_nxt;
      out_exc_p_o     <= iq_has_exc_p_i & mode;
      out_inst_p_o    <= iq_inst_p_i;
      out_vaddr_p_o   <= iq_vaddr_p_i;
      out_exccode_p_o <= iq_exccode_p_i;
    end
  end

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed scoreboard bench for issue_arbiter: per-step expected dequeue count and output packet.
// Latency: expected packet is queued at drive time and compared 1 cycle later.
// Backpressure: stall steps expect the previous packet to be held.
module tb_issue_arbiter;

  localparam logic [31:0] ADDU3    = 32'h00221821; // addu $3,$1,$2
  localparam logic [31:0] ADDU_RS3 = 32'h00652021; // addu $4,$3,$5
  localparam logic [31:0] ADDU_RT3 = 32'h00A32021; // addu $4,$5,$3
  localparam logic [31:0] ADDU_IND = 32'h00E83021; // addu $6,$7,$8
  localparam logic [31:0] ADDU_R31 = 32'h03E22821; // addu $5,$31,$2
  localparam logic [31:0] LW9      = 32'h8D490000; // lw $9,0($10)
  localparam logic [31:0] SW11     = 32'hAD8B0004; // sw $11,4($12)
  localparam logic [31:0] BEQ      = 32'h10220004;
  localparam logic [31:0] BNE      = 32'h14220004;
  localparam logic [31:0] MULT     = 32'h00220018;
  localparam logic [31:0] SYSCALL  = 32'h0000000C;
  localparam logic [31:0] JAL      = 32'h0C000010;
  localparam logic [31:0] BGEZAL   = 32'h04310004;

  typedef struct packed {
    logic [1:0]  valid;
    logic [1:0]  ds;
    logic [1:0]  exc;
    logic [63:0] inst;
    logic [63:0] vaddr;
    logic [9:0]  code;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [1:0]  iq_supply_valid_i;
  logic [63:0] iq_inst_p_i;
  logic [63:0] iq_vaddr_p_i;
  logic [1:0]  iq_has_exc_p_i;
  logic [9:0]  iq_exccode_p_i;
  logic        ex_ready_i;
  logic [1:0]  upd_mode_o;
  logic [1:0]  out_valid_o;
  logic [63:0] out_inst_p_o;
  logic [63:0] out_vaddr_p_o;
  logic [1:0]  out_exc_p_o;
  logic [9:0]  out_exccode_p_o;
  logic [1:0]  out_is_ds_o;

  int          n_checks = 0;
  int          n_errors = 0;
  pkt_t        sb[$];
  pkt_t        model;
  logic [31:0] pc = 32'hBFC0_0000;

  always #5 clk = ~clk;

  issue_arbiter dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .iq_supply_valid_i(iq_supply_valid_i), .iq_inst_p_i(iq_inst_p_i),
    .iq_vaddr_p_i(iq_vaddr_p_i), .iq_has_exc_p_i(iq_has_exc_p_i),
    .iq_exccode_p_i(iq_exccode_p_i), .ex_ready_i(ex_ready_i),
    .upd_mode_o(upd_mode_o), .out_valid_o(out_valid_o),
    .out_inst_p_o(out_inst_p_o), .out_vaddr_p_o(out_vaddr_p_o),
    .out_exc_p_o(out_exc_p_o), .out_exccode_p_o(out_exccode_p_o),
    .out_is_ds_o(out_is_ds_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive, check dequeue count, predict the packet, compare it after the edge
  task automatic step(input string tag, input logic rstv, input logic fl, input logic rdy,
                      input logic [1:0] sup, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] exc, input logic [1:0] exp_mode,
                      input logic [1:0] exp_ds);
    pkt_t got;
    pkt_t exp;
    @(negedge clk);
    rst               = rstv;
    flush_i           = fl;
    ex_ready_i        = rdy;
    iq_supply_valid_i = sup;
    iq_inst_p_i       = {i1, i0};
    iq_vaddr_p_i      = {pc + 32'd4, pc};
    iq_has_exc_p_i    = exc;
    iq_exccode_p_i    = 10'($urandom);
    #1;
    chk($sformatf("%s.upd_mode", tag), 64'(upd_mode_o), 64'(exp_mode));
    if (!rstv) begin
      model = '0;
    end else if (fl) begin
      model.valid = 2'b00;
      model.ds    = 2'b00;
      model.exc   = 2'b00;
    end else if (rdy) begin
      model.valid = exp_mode;
      model.ds    = exp_ds;
      model.exc   = exc & exp_mode;
      model.inst  = {i1, i0};
      model.vaddr = {pc + 32'd4, pc};
      model.code  = iq_exccode_p_i;
    end
    sb.push_back(model);
    pc = pc + 32'd8;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("%s.sb_empty", tag), 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      got = '{out_valid_o, out_is_ds_o, out_exc_p_o, out_inst_p_o, out_vaddr_p_o,
              out_exccode_p_o};
      chk($sformatf("%s.valid", tag), 64'(got.valid), 64'(exp.valid));
      chk($sformatf("%s.is_ds", tag), 64'(got.ds), 64'(exp.ds));
      chk($sformatf("%s.exc", tag), 64'(got.exc), 64'(exp.exc));
      chk($sformatf("%s.inst", tag), got.inst, exp.inst);
      chk($sformatf("%s.vaddr", tag), got.vaddr, exp.vaddr);
      chk($sformatf("%s.exccode", tag), 64'(got.code), 64'(exp.code));
    end
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1; iq_supply_valid_i = 2'b00;
    iq_inst_p_i = '0; iq_vaddr_p_i = '0; iq_has_exc_p_i = 2'b00; iq_exccode_p_i = '0;
    model = '0;

    //   tag           rst fl  rdy sup    slot0     slot1     exc    mode   ds
    step("reset",      0, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b11, 2'b00, 2'b00);
    step("raw_rs",     1, 0, 1, 2'b11, ADDU3,    ADDU_RS3, 2'b00, 2'b01, 2'b00);
    step("raw_rt",     1, 0, 1, 2'b11, ADDU3,    ADDU_RT3, 2'b00, 2'b01, 2'b00);
    step("dual",       1, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b00, 2'b11, 2'b00);
    step("mem_pair",   1, 0, 1, 2'b11, LW9,      SW11,     2'b00, 2'b01, 2'b00);
    step("empty",      1, 0, 1, 2'b00, ADDU3,    ADDU_IND, 2'b00, 2'b00, 2'b00);
    step("one_only",   1, 0, 1, 2'b01, ADDU3,    ADDU_IND, 2'b00, 2'b01, 2'b00);
    step("br_wait",    1, 0, 1, 2'b01, BEQ,      32'h0,    2'b00, 2'b00, 2'b00);
    step("br_dual",    1, 0, 1, 2'b11, BEQ,      ADDU_IND, 2'b00, 2'b11, 2'b10);
    step("br_single",  1, 0, 1, 2'b11, BNE,      MULT,     2'b00, 2'b01, 2'b00);
    step("ds_issue",   1, 0, 1, 2'b01, MULT,     32'h0,    2'b00, 2'b01, 2'b01);
    step("idle_dual",  1, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b00, 2'b11, 2'b00);
    for (int i = 0; i < 3; i++)
      step("stall",    1, 0, 0, 2'b11, ADDU_IND, ADDU3,    2'b01, 2'b00, 2'b00);
    step("stall_rel",  1, 0, 1, 2'b11, ADDU_IND, ADDU3,    2'b00, 2'b11, 2'b00);
    step("fl_br",      1, 0, 1, 2'b11, BNE,      MULT,     2'b00, 2'b01, 2'b00);
    step("flush",      1, 1, 1, 2'b11, ADDU3,    ADDU_IND, 2'b00, 2'b00, 2'b00);
    step("post_flush", 1, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b00, 2'b11, 2'b00);
    step("rst_br",     1, 0, 1, 2'b11, BNE,      MULT,     2'b10, 2'b01, 2'b00);
    step("rst_mid",    0, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b00, 2'b00, 2'b00);
    step("post_rst",   1, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b00, 2'b11, 2'b00);
    step("exc_slot1",  1, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b10, 2'b01, 2'b00);
    step("exc_slot0",  1, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b01, 2'b01, 2'b00);
    step("ser_slot1",  1, 0, 1, 2'b11, ADDU3,    SYSCALL,  2'b00, 2'b01, 2'b00);
    step("ser_slot0",  1, 0, 1, 2'b11, MULT,     ADDU_IND, 2'b00, 2'b01, 2'b00);
    step("br_slot1",   1, 0, 1, 2'b11, ADDU3,    BEQ,      2'b00, 2'b01, 2'b00);
    step("link_dual",  1, 0, 1, 2'b11, BGEZAL,   ADDU_IND, 2'b00, 2'b11, 2'b10);
    step("jal_raw",    1, 0, 1, 2'b11, JAL,      ADDU_R31, 2'b00, 2'b01, 2'b00);
    step("ds_one",     1, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b00, 2'b01, 2'b01);
    step("dsw_br",     1, 0, 1, 2'b11, BEQ,      MULT,     2'b00, 2'b01, 2'b00);
    step("dsw_stall",  1, 0, 0, 2'b01, ADDU3,    32'h0,    2'b00, 2'b00, 2'b00);
    step("dsw_empty",  1, 0, 1, 2'b00, ADDU3,    32'h0,    2'b00, 2'b00, 2'b00);
    step("dsw_go",     1, 0, 1, 2'b01, ADDU3,    32'h0,    2'b01, 2'b01, 2'b01);
    step("after_ds",   1, 0, 1, 2'b11, ADDU3,    ADDU_IND, 2'b00, 2'b11, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
